// File: rtl/axi_llc_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : axi_llc_pkg                                                     |
// | Purpose  : Shared LLC types and helpers: configuration structs, default    |
// |            AX channel and descriptor structs, AX acceptor FSM states,      |
// |            cache-line geometry and per-line beat computation.              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

package axi_llc_pkg;

  typedef struct packed {
    int unsigned BlockSize;    // bits per block
    int unsigned NumBlocks;    // blocks per cache line
    int unsigned TagLength;
    int unsigned IndexLength;
  } llc_cfg_t;

  typedef struct packed {
    int unsigned SlvPortIdWidth;
    int unsigned AddrWidthFull;
  } llc_axi_cfg_t;

  localparam llc_cfg_t DefaultCfg = '{
    BlockSize: 64, NumBlocks: 8, TagLength: 20, IndexLength: 6
  };
  localparam llc_axi_cfg_t DefaultAxiCfg = '{
    SlvPortIdWidth: 4, AddrWidthFull: 32
  };

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] BurstWrap  = 2'b10;

  // Slave-port AX channel matching DefaultAxiCfg.
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
  } llc_ax_chan_t;

  // Per-cache-line descriptor handed to the descriptor pipeline.
  typedef struct packed {
    logic [3:0]  a_x_id;
    logic [31:0] a_x_addr;
    logic [7:0]  a_x_len;
    logic [2:0]  a_x_size;
    logic [1:0]  a_x_burst;
    logic        a_x_lock;
    logic [3:0]  a_x_cache;
    logic [2:0]  a_x_prot;
    logic        rw;
    logic        x_last;
  } llc_desc_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } ax_slave_state_e;

  // Bytes in one cache line.
  function automatic int unsigned line_bytes(input llc_cfg_t cfg);
    return cfg.BlockSize / 8 * cfg.NumBlocks;
  endfunction

  localparam int unsigned DefaultLineBytes = line_bytes(DefaultCfg);

  // Beats of the remaining burst that still fit in the current cache line.
  // A beat wider than what is left of the line would give zero; one beat is
  // the minimum so the split always makes progress.
  function automatic logic [8:0] line_beats(input logic [63:0]  addr,
                                            input logic [2:0]   size,
                                            input logic [8:0]   beats,
                                            input int unsigned  lbytes);
    logic [31:0] off;
    logic [31:0] to_end;
    logic [31:0] n;
    off    = 32'(addr % 64'(lbytes));
    to_end = (lbytes - off) >> size;
    n      = (32'(beats) < to_end) ? 32'(beats) : to_end;
    if (n == 32'd0) n = 32'd1;
    return 9'(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/axi_llc_ax_slave.sv
// +----------------------------------------------------------------------------+
// | Module   : axi_llc_ax_slave                                                |
// | Purpose  : Accepts one AXI AW/AR request and splits an INCR burst into one |
// |            descriptor per touched cache line. FIXED and WRAP bursts pass   |
// |            through as a single descriptor. One burst in flight.            |
// | Ports    : clk_i, rst_i (async, active-high)                               |
// |            ax_chan_slv_i / ax_chan_valid_i / ax_chan_ready_o : AX input    |
// |            desc_o / desc_valid_o / desc_ready_i : descriptor output        |
// |            split_cnt_o : bursts split into >1 descriptor (optional)        |
// | Options  : AXI_LLC_AX_SLAVE_PERF_EN adds split_cnt_o and its counter.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module axi_llc_ax_slave
  import axi_llc_pkg::*;
#(
  parameter llc_cfg_t     Cfg       = DefaultCfg,
  parameter llc_axi_cfg_t AxiCfg    = DefaultAxiCfg,
  parameter type          desc_t    = llc_desc_t,
  parameter type          ax_chan_t = llc_ax_chan_t,
  parameter logic         RwWrite   = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  ax_chan_t    ax_chan_slv_i,
  input  logic        ax_chan_valid_i,
  output logic        ax_chan_ready_o,
  output desc_t       desc_o,
  output logic        desc_valid_o,
  input  logic        desc_ready_i
`ifdef AXI_LLC_AX_SLAVE_PERF_EN
  ,
  output logic [31:0] split_cnt_o
`endif
);

  localparam int unsigned LineBytes = line_bytes(Cfg);
  localparam int unsigned AddrW     = AxiCfg.AddrWidthFull;
  localparam logic [AddrW-1:0] LineMask = AddrW'(LineBytes - 1);
  localparam logic [AddrW-1:0] LineInc  = AddrW'(LineBytes);

  ax_slave_state_e state_q, state_d;
  // The addr field of the registered request is the running line address.
  ax_chan_t        ax_q, ax_d;
  logic [8:0]      beats_q, beats_d;

  logic       is_incr;
  logic [8:0] n_beats;
  logic       x_last;
  logic       ax_hs;
  logic       desc_hs;

  assign is_incr = (ax_q.burst == BurstIncr);
  assign n_beats = is_incr ? line_beats(64'(ax_q.addr), ax_q.size, beats_q, LineBytes)
                           : beats_q;
  assign x_last  = (n_beats == beats_q);
  assign ax_hs   = ax_chan_valid_i & ax_chan_ready_o;
  assign desc_hs = desc_valid_o & desc_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ax_q    <= '0;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      ax_q    <= ax_d;
      beats_q <= beats_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    ax_d            = ax_q;
    beats_d         = beats_q;
    ax_chan_ready_o = 1'b0;
    desc_valid_o    = 1'b0;
    desc_o          = '0;
    case (state_q)
      IDLE: begin
        ax_chan_ready_o = 1'b1;
        if (ax_chan_valid_i) begin
          ax_d    = ax_chan_slv_i;
          beats_d = {1'b0, ax_chan_slv_i.len} + 9'd1;
          state_d = SPLIT;
        end
      end
      SPLIT: begin
        desc_valid_o     = 1'b1;
        desc_o.a_x_id    = ax_q.id;
        desc_o.a_x_addr  = ax_q.addr;
        desc_o.a_x_len   = is_incr ? 8'(n_beats - 9'd1) : ax_q.len;
        desc_o.a_x_size  = ax_q.size;
        desc_o.a_x_burst = ax_q.burst;
        desc_o.a_x_lock  = ax_q.lock;
        desc_o.a_x_cache = ax_q.cache;
        desc_o.a_x_prot  = ax_q.prot;
        desc_o.rw        = RwWrite;
        desc_o.x_last    = x_last;
        if (desc_ready_i) begin
          if (x_last) begin
            state_d = IDLE;
          end else begin
            // Continue at the next line boundary; wraps modulo the address space.
            ax_d.addr = (ax_q.addr & ~LineMask) + LineInc;
            beats_d   = beats_q - n_beats;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef AXI_LLC_AX_SLAVE_PERF_EN
  logic        first_q;
  logic [31:0] split_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      first_q     <= 1'b0;
      split_cnt_q <= '0;
    end else begin
      if (ax_hs) begin
        first_q <= 1'b1;
      end else if (desc_hs) begin
        first_q <= 1'b0;
      end
      if (desc_hs && first_q && !x_last && (split_cnt_q != '1)) begin
        split_cnt_q <= split_cnt_q + 32'd1;
      end
    end
  end

  assign split_cnt_o = split_cnt_q;
`endif

  // Held descriptor must not change while the consumer stalls.
  a_desc_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (desc_valid_o && !desc_ready_i) |=> (desc_valid_o && $stable(desc_o)));

  // A WRAP burst must fit inside one cache line.
  a_wrap_fits: assert property (@(posedge clk_i) disable iff (rst_i)
    (ax_hs && (ax_chan_slv_i.burst == BurstWrap)) |->
      (((32'(ax_chan_slv_i.len) + 32'd1) << ax_chan_slv_i.size) <= LineBytes));

endmodule

`default_nettype wire
